// File: rtl/binary_to_n_decoder_pipelined.sv
// Registered, offset-aware binary-to-one-hot decoder with hit/miss flags and a PIPE_DEPTH valid pipeline.
// Optional saturating miss counter and port miss_count enabled by `define BINARY_TO_N_DECODER_MISS_COUNT_EN.
module binary_to_n_decoder_pipelined #(
  parameter int unsigned BINARY_WIDTH     = 8,
  parameter int unsigned OUTPUT_WIDTH     = 8,
  parameter logic [63:0] BASE_ADDR        = 64'd0,
  parameter int unsigned PIPE_DEPTH       = 1,
  parameter bit          HOLD_LAST        = 1'b0,
  parameter int unsigned MISS_COUNT_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        clock_enable,
  input  logic [BINARY_WIDTH-1:0]     in,
  input  logic                        in_valid,
  output logic [OUTPUT_WIDTH-1:0]     out,
  output logic                        out_valid,
  output logic                        out_hit,
  output logic                        out_miss
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
  ,
  output logic [MISS_COUNT_WIDTH-1:0] miss_count
`endif
);

  // Range compare is done wide enough that BASE_ADDR+OUTPUT_WIDTH never wraps.
  localparam int unsigned XW = 66;
  localparam logic [XW-1:0] BASE_X  = XW'(BASE_ADDR);
  localparam logic [XW-1:0] LIMIT_X = BASE_X + XW'(OUTPUT_WIDTH);
  localparam int unsigned LAST = PIPE_DEPTH - 1;

  if (BINARY_WIDTH < 1 || BINARY_WIDTH > 64) begin : g_bad_binary_width
    $error("BINARY_WIDTH must be 1..64");
  end
  if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > 256) begin : g_bad_output_width
    $error("OUTPUT_WIDTH must be 1..256");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
    $error("PIPE_DEPTH must be 1..4");
  end
  if (MISS_COUNT_WIDTH < 1) begin : g_bad_miss_count_width
    $error("MISS_COUNT_WIDTH must be at least 1");
  end

  logic [XW-1:0]           w_addr_x;
  logic [BINARY_WIDTH:0]   w_offset;
  logic                    w_hit;
  logic [OUTPUT_WIDTH-1:0] w_onehot;

  always_comb begin
    w_addr_x = XW'(in);
    w_offset = w_addr_x[BINARY_WIDTH:0] - BASE_X[BINARY_WIDTH:0];
    w_hit    = (w_addr_x >= BASE_X) && (w_addr_x < LIMIT_X);
    w_onehot = '0;
    if (in_valid && w_hit) begin
      w_onehot = OUTPUT_WIDTH'(1) << w_offset;
    end
  end

  logic [PIPE_DEPTH-1:0]                   r_valid = '0;
  logic [PIPE_DEPTH-1:0]                   r_hit   = '0;
  logic [PIPE_DEPTH-1:0][OUTPUT_WIDTH-1:0] r_out   = '0;
  logic [OUTPUT_WIDTH-1:0]                 r_held  = '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_valid <= '0;
      r_hit   <= '0;
      r_out   <= '0;
    end else if (clock_enable) begin
      r_valid[0] <= in_valid;
      r_hit[0]   <= in_valid & w_hit;
      r_out[0]   <= w_onehot;
      for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_hit[s]   <= r_hit[s-1];
        r_out[s]   <= r_out[s-1];
      end
    end
  end

  // Held value tracks the last valid final-stage word; a miss word is zero, so a miss clears it.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_held <= '0;
    end else if (clock_enable && r_valid[LAST]) begin
      r_held <= r_out[LAST];
    end
  end

  always_comb begin
    out_valid = r_valid[LAST];
    out_hit   = r_valid[LAST] & r_hit[LAST];
    out_miss  = r_valid[LAST] & ~r_hit[LAST];
    out       = r_out[LAST];
    if (HOLD_LAST && !r_valid[LAST]) begin
      out = r_held;
    end
  end

`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
  logic [MISS_COUNT_WIDTH-1:0] r_miss_count = '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_miss_count <= '0;
    end else if (clock_enable && out_miss && (r_miss_count != '1)) begin
      r_miss_count <= r_miss_count + MISS_COUNT_WIDTH'(1);
    end
  end

  always_comb miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_binary_to_n_decoder_pipelined.sv
// Scoreboard bench for binary_to_n_decoder_pipelined: main (BASE 3), high-base (BASE 12) and hold/miss-count instances.
module tb_binary_to_n_decoder_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       ce  = 1'b1;
  logic [3:0] m_in = '0, b_in = '0, h_in = '0;
  logic       m_vld = 1'b0, b_vld = 1'b0, h_vld = 1'b0;

  logic [5:0] m_out, b_out, h_out;
  logic       m_ov, m_oh, m_om;
  logic       b_ov, b_oh, b_om;
  logic       h_ov, h_oh, h_om;
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
  logic [7:0] m_mc, b_mc;
  logic [1:0] h_mc;
`endif

  binary_to_n_decoder_pipelined #(
    .BINARY_WIDTH(4), .OUTPUT_WIDTH(6), .BASE_ADDR(64'd3), .PIPE_DEPTH(2),
    .HOLD_LAST(1'b0), .MISS_COUNT_WIDTH(8)
  ) dut (
    .clock(clk), .clear(clr), .clock_enable(ce), .in(m_in), .in_valid(m_vld),
    .out(m_out), .out_valid(m_ov), .out_hit(m_oh), .out_miss(m_om)
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    , .miss_count(m_mc)
`endif
  );

  binary_to_n_decoder_pipelined #(
    .BINARY_WIDTH(4), .OUTPUT_WIDTH(6), .BASE_ADDR(64'd12), .PIPE_DEPTH(2),
    .HOLD_LAST(1'b0), .MISS_COUNT_WIDTH(8)
  ) dut_b (
    .clock(clk), .clear(clr), .clock_enable(ce), .in(b_in), .in_valid(b_vld),
    .out(b_out), .out_valid(b_ov), .out_hit(b_oh), .out_miss(b_om)
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    , .miss_count(b_mc)
`endif
  );

  binary_to_n_decoder_pipelined #(
    .BINARY_WIDTH(4), .OUTPUT_WIDTH(6), .BASE_ADDR(64'd3), .PIPE_DEPTH(2),
    .HOLD_LAST(1'b1), .MISS_COUNT_WIDTH(2)
  ) dut_h (
    .clock(clk), .clear(clr), .clock_enable(ce), .in(h_in), .in_valid(h_vld),
    .out(h_out), .out_valid(h_ov), .out_hit(h_oh), .out_miss(h_om)
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    , .miss_count(h_mc)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned en_cnt = 0;
  logic        stalled_edge = 1'b0;
  logic [8:0]  snap = '0;

  typedef struct {
    logic [5:0]  o;
    logic        h;
    int unsigned due;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];

  always @(posedge clk) begin
    if (ce && !clr) en_cnt <= en_cnt + 1;
    stalled_edge <= !ce && !clr;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Main-instance monitor: pops one expectation per valid output after an enabled edge.
  always @(negedge clk) begin
    exp_t e;
    if (stalled_edge) begin
      chk("main_stall_freeze", {m_out, m_ov, m_oh, m_om}, snap);
    end else if (m_ov) begin
      if (q.size() == 0) begin
        chk("main_unexpected_valid", m_ov, 1'b0);
      end else begin
        e = q.pop_front();
        chk("main_out", m_out, e.o);
        chk("main_hit", m_oh, e.h);
        chk("main_miss", m_om, !e.h);
        chk("main_latency", en_cnt, e.due);
      end
    end else begin
      chk("main_idle_zero", {m_out, m_oh, m_om}, '0);
      if (q.size() != 0 && q[0].due <= en_cnt) begin
        e = q.pop_front();
        chk("main_missing_valid", m_ov, 1'b1);
      end
    end
    snap = {m_out, m_ov, m_oh, m_om};
  end

  always @(negedge clk) begin
    exp_t e;
    if (!stalled_edge) begin
      if (b_ov) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", b_ov, 1'b0);
        end else begin
          e = qb.pop_front();
          chk("b_out", b_out, e.o);
          chk("b_hit", b_oh, e.h);
          chk("b_miss", b_om, !e.h);
          chk("b_latency", en_cnt, e.due);
        end
      end else begin
        chk("b_idle_zero", {b_out, b_oh, b_om}, '0);
        if (qb.size() != 0 && qb[0].due <= en_cnt) begin
          e = qb.pop_front();
          chk("b_missing_valid", b_ov, 1'b1);
        end
      end
    end
  end

  task automatic drive(input logic c, input logic e);
    @(negedge clk);
    clr = c; ce = e;
    m_vld = 1'b0; b_vld = 1'b0; h_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1);
  endtask

  task automatic issue(input logic [3:0] a, input logic [5:0] eo, input logic eh);
    drive(1'b0, 1'b1);
    m_in = a; m_vld = 1'b1;
    q.push_back('{o: eo, h: eh, due: en_cnt + 2});
  endtask

  task automatic issue_b(input logic [3:0] a, input logic [5:0] eo, input logic eh);
    drive(1'b0, 1'b1);
    b_in = a; b_vld = 1'b1;
    qb.push_back('{o: eo, h: eh, due: en_cnt + 2});
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0);
      m_in = 4'd7; m_vld = 1'b1;
    end
  endtask

  // Clear lands on the edge that would capture 'a'; pending expectations are dropped after it.
  task automatic clear_with(input logic [3:0] a, input logic e);
    drive(1'b1, e);
    m_in = a; m_vld = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    qb.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", m_ov, 1'b0);
    chk("reset_out", m_out, 6'd0);
    chk("reset_hold_out", h_out, 6'd0);
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    chk("reset_miss_count", h_mc, 2'd0);
`endif
    idle(1);

    issue(4'd5, 6'b000100, 1'b1);
    idle(3);

    issue(4'd3,  6'b000001, 1'b1);
    issue(4'd8,  6'b100000, 1'b1);
    issue(4'd9,  6'b000000, 1'b0);
    issue(4'd2,  6'b000000, 1'b0);
    issue(4'd15, 6'b000000, 1'b0);
    issue(4'd0,  6'b000000, 1'b0);
    idle(3);

    issue(4'd4, 6'b000010, 1'b1);
    stall(3);
    issue(4'd6, 6'b001000, 1'b1);
    idle(3);

    issue(4'd5, 6'b000100, 1'b1);
    clear_with(4'd7, 1'b1);
    idle(4);
    issue(4'd4, 6'b000010, 1'b1);
    clear_with(4'd7, 1'b0);
    idle(4);
    issue(4'd8, 6'b100000, 1'b1);
    idle(3);

    issue_b(4'd15, 6'b001000, 1'b1);
    issue_b(4'd0,  6'b000000, 1'b0);
    issue_b(4'd1,  6'b000000, 1'b0);
    issue_b(4'd12, 6'b000001, 1'b1);
    idle(3);

    drive(1'b0, 1'b1);
    h_in = 4'd4; h_vld = 1'b1;
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("hold_first_valid", h_ov, 1'b1);
    chk("hold_first_out", h_out, 6'b000010);
    chk("hold_first_hit", h_oh, 1'b1);
    repeat (4) drive(1'b0, 1'b1);
    chk("hold_idle_valid", h_ov, 1'b0);
    chk("hold_idle_out", h_out, 6'b000010);
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    chk("hold_count_before_miss", h_mc, 2'd0);
`endif
    repeat (5) begin
      drive(1'b0, 1'b1);
      h_in = 4'd0; h_vld = 1'b1;
    end
    repeat (7) drive(1'b0, 1'b1);
    chk("hold_after_miss_out", h_out, 6'd0);
    chk("hold_after_miss_valid", h_ov, 1'b0);
`ifdef BINARY_TO_N_DECODER_MISS_COUNT_EN
    chk("miss_count_saturated", h_mc, 2'd3);
`endif

    idle(2);
    chk("main_queue_drained", q.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
